// File: rtl/if_restart_ctrl_pkg.sv
// Shared types for the instruction-fetch restart controller.
package IF_pkg;

    // Default program-counter width; restart_req_t carries a PC of this width.
    localparam int unsigned PC_BITS_DEF = 32;

    typedef enum logic [1:0] {
        CAUSE_FLUSH     = 2'd0,
        CAUSE_INV_PRED  = 2'd1,
        CAUSE_INV_INSTR = 2'd2,
        CAUSE_RETURN    = 2'd3
    } restart_cause_t;

    typedef struct packed {
        logic                   valid;
        restart_cause_t         cause;
        logic [PC_BITS_DEF-1:0] pc;
    } restart_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } restart_state_t;

endpackage

// File: rtl/if_restart_ctrl_prio.sv
// Combinational priority encoder: flush beats every low-tier request, and
// among low-tier requests invalid_prediction > invalid_instruction > return.
module if_restart_prio
    import IF_pkg::*;
(
    input  logic                   must_flush,
    input  logic [PC_BITS_DEF-1:0] correct_address,
    input  logic                   invalid_prediction,
    input  logic                   invalid_instruction,
    input  logic                   is_return_in,
    input  logic [PC_BITS_DEF-1:0] old_PC,
    input  logic [PC_BITS_DEF-1:0] ras_target,
    output restart_req_t           req,
    output logic                   multi_low,
    output logic                   in_drop
);

    logic any_low;

    // Select the winning request and flag requests lost in this same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        req       = '0;
        any_low   = invalid_prediction | invalid_instruction | is_return_in;
        multi_low = (invalid_prediction & invalid_instruction) |
                    (invalid_prediction & is_return_in) |
                    (invalid_instruction & is_return_in);
        // At most one drop per cycle is counted for same-cycle losers.
        in_drop   = (must_flush & any_low) | multi_low;

        if (must_flush) begin
            req = '{valid: 1'b1, cause: CAUSE_FLUSH, pc: correct_address};
        end else if (invalid_prediction) begin
            req = '{valid: 1'b1, cause: CAUSE_INV_PRED, pc: old_PC};
        end else if (invalid_instruction) begin
            req = '{valid: 1'b1, cause: CAUSE_INV_INSTR, pc: old_PC};
        end else if (is_return_in) begin
            req = '{valid: 1'b1, cause: CAUSE_RETURN, pc: ras_target};
        end
    end

endmodule

// File: rtl/if_restart_ctrl.sv
// Restart controller: arbitrates flush/restart requests into one pending
// redirect, holds it through icache misses and hands it over on valid/ready.
module if_restart_ctrl
    import IF_pkg::*;
#(
    parameter int unsigned PC_BITS = PC_BITS_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               must_flush,
    input  logic [PC_BITS-1:0] correct_address,
    input  logic               invalid_prediction,
    input  logic               invalid_instruction,
    input  logic               is_return_in,
    input  logic [PC_BITS-1:0] old_PC,
    input  logic [PC_BITS-1:0] ras_target,
    input  logic               icache_miss,
    input  logic               redirect_ready,
    output logic               redirect_valid,
    output logic [PC_BITS-1:0] redirect_pc,
    output logic [1:0]         redirect_cause,
    output logic               btb_invalidate,
    output logic [PC_BITS-1:0] btb_inv_pc,
    output logic               fq_flush,
    output logic               multi_req_err,
    output logic [CNT_W-1:0]   dropped_cnt
);

    restart_state_t state_q, state_d;
    restart_cause_t pend_cause_q, pend_cause_d;
    logic [PC_BITS-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               multi_q;

    restart_req_t req;
    logic         multi_low;
    logic         in_drop;
    logic         acc;
    logic [1:0]   drop_amt;
    logic [CNT_W:0] cnt_sum;

    if_restart_prio u_prio (
        .must_flush          (must_flush),
        .correct_address     (correct_address),
        .invalid_prediction  (invalid_prediction),
        .invalid_instruction (invalid_instruction),
        .is_return_in        (is_return_in),
        .old_PC              (old_PC),
        .ras_target          (ras_target),
        .req                 (req),
        .multi_low           (multi_low),
        .in_drop             (in_drop)
    );

    assign acc = (state_q == HOLD) && redirect_ready && !icache_miss;

    // Next-state, pending-redirect merge rules and drop accounting.
    always_comb begin
        state_d      = state_q;
        pend_cause_d = pend_cause_q;
        pend_pc_d    = pend_pc_q;
        drop_amt     = {1'b0, in_drop};

        unique case (state_q)
            IDLE: begin
                if (req.valid) begin
                    pend_cause_d = req.cause;
                    pend_pc_d    = req.pc;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (acc) begin
                    // The accepted redirect retires; a same-cycle request takes its place.
                    if (req.valid) begin
                        pend_cause_d = req.cause;
                        pend_pc_d    = req.pc;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req.valid) begin
                    if (req.cause == CAUSE_FLUSH) begin
                        // Latest flush wins; overwriting a low-tier restart loses it.
                        pend_cause_d = req.cause;
                        pend_pc_d    = req.pc;
                        if (pend_cause_q != CAUSE_FLUSH) begin
                            drop_amt = drop_amt + 2'd1;
                        end
                    end else begin
                        // Older pending redirect wins over a new low-tier restart.
                        drop_amt = drop_amt + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturating add: the extra top bit catches overflow.
        cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, drop_amt};
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // State, pending redirect, drop counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_cause_q <= CAUSE_FLUSH;
            pend_pc_q    <= '0;
            cnt_q        <= '0;
            multi_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            pend_cause_q <= pend_cause_d;
            pend_pc_q    <= pend_pc_d;
            cnt_q        <= cnt_d;
            multi_q      <= multi_low;
        end
    end

    assign redirect_valid = (state_q == HOLD);
    assign redirect_pc    = {pend_pc_q[PC_BITS-1:1], 1'b0};
    assign redirect_cause = pend_cause_q;
    assign fq_flush       = acc;
    assign btb_invalidate = acc && (pend_cause_q == CAUSE_INV_PRED);
    assign btb_inv_pc     = btb_invalidate ? pend_pc_q : '0;
    assign multi_req_err  = multi_q;
    assign dropped_cnt    = cnt_q;

endmodule

// File: tb/tb_if_restart_ctrl.sv
// Directed self-checking bench for if_restart_ctrl.
module tb_if_restart_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        must_flush;
    logic [31:0] correct_address;
    logic        invalid_prediction;
    logic        invalid_instruction;
    logic        is_return_in;
    logic [31:0] old_PC;
    logic [31:0] ras_target;
    logic        icache_miss;
    logic        redirect_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  redirect_cause;
    logic        btb_invalidate;
    logic [31:0] btb_inv_pc;
    logic        fq_flush;
    logic        multi_req_err;
    logic [2:0]  dropped_cnt;

    int checks   = 0;
    int failures = 0;

    // Small counter width so saturation is reachable in a few cycles.
    if_restart_ctrl #(.PC_BITS(32), .CNT_W(3)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .must_flush          (must_flush),
        .correct_address     (correct_address),
        .invalid_prediction  (invalid_prediction),
        .invalid_instruction (invalid_instruction),
        .is_return_in        (is_return_in),
        .old_PC              (old_PC),
        .ras_target          (ras_target),
        .icache_miss         (icache_miss),
        .redirect_ready      (redirect_ready),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_cause      (redirect_cause),
        .btb_invalidate      (btb_invalidate),
        .btb_inv_pc          (btb_inv_pc),
        .fq_flush            (fq_flush),
        .multi_req_err       (multi_req_err),
        .dropped_cnt         (dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        must_flush          = 1'b0;
        invalid_prediction  = 1'b0;
        invalid_instruction = 1'b0;
        is_return_in        = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        clear_req();
        correct_address = '0;
        old_PC          = '0;
        ras_target      = '0;
        icache_miss     = 1'b0;
        redirect_ready  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_valid", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_cause", redirect_cause, 0);
        check("rst_fq", fq_flush, 0);
        check("rst_btb", btb_invalidate, 0);
        check("rst_drop", dropped_cnt, 0);

        // Refetch with immediate acceptance.
        redirect_ready      = 1'b1;
        invalid_instruction = 1'b1;
        old_PC              = 32'h40;
        tick();
        clear_req();
        #1;
        check("t1_valid", redirect_valid, 1);
        check("t1_pc", redirect_pc, 32'h40);
        check("t1_cause", redirect_cause, 2);
        check("t1_fq", fq_flush, 1);
        check("t1_btb", btb_invalidate, 0);
        tick();
        check("t1_idle", redirect_valid, 0);
        check("t1_fq_off", fq_flush, 0);

        // Mispredict held through a 5-cycle miss.
        icache_miss        = 1'b1;
        invalid_prediction = 1'b1;
        old_PC             = 32'h88;
        tick();
        clear_req();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_hold_valid", redirect_valid, 1);
            check("t2_hold_pc", redirect_pc, 32'h88);
            check("t2_hold_fq", fq_flush, 0);
            tick();
        end
        icache_miss = 1'b0;
        #1;
        check("t2_btb", btb_invalidate, 1);
        check("t2_btb_pc", btb_inv_pc, 32'h88);
        check("t2_fq", fq_flush, 1);
        tick();
        check("t2_idle", redirect_valid, 0);

        // Return pending, then a flush overwrites it under miss.
        icache_miss  = 1'b1;
        is_return_in = 1'b1;
        ras_target   = 32'h200;
        tick();
        clear_req();
        check("t3_ret_pc", redirect_pc, 32'h200);
        check("t3_ret_cause", redirect_cause, 3);
        tick();
        must_flush      = 1'b1;
        correct_address = 32'h1000;
        tick();
        clear_req();
        check("t3_flush_pc", redirect_pc, 32'h1000);
        check("t3_flush_cause", redirect_cause, 0);
        check("t3_drop", dropped_cnt, 1);

        // Mispredict while a flush is pending is discarded.
        invalid_prediction = 1'b1;
        old_PC             = 32'h300;
        tick();
        clear_req();
        check("t4_pc", redirect_pc, 32'h1000);
        check("t4_cause", redirect_cause, 0);
        check("t4_drop", dropped_cnt, 2);
        icache_miss = 1'b0;
        #1;
        check("t4_fq", fq_flush, 1);
        check("t4_btb", btb_invalidate, 0);
        tick();
        check("t4_idle", redirect_valid, 0);

        // Two low-tier requests in one cycle.
        icache_miss        = 1'b1;
        invalid_prediction = 1'b1;
        is_return_in       = 1'b1;
        old_PC             = 32'h500;
        ras_target         = 32'h600;
        tick();
        clear_req();
        check("t5_err", multi_req_err, 1);
        check("t5_cause", redirect_cause, 1);
        check("t5_pc", redirect_pc, 32'h500);
        check("t5_drop", dropped_cnt, 3);
        tick();
        check("t5_err_off", multi_req_err, 0);

        // New request in the same cycle as acceptance stays in HOLD.
        icache_miss  = 1'b0;
        is_return_in = 1'b1;
        ras_target   = 32'h600;
        #1;
        check("t6_btb", btb_invalidate, 1);
        check("t6_btb_pc", btb_inv_pc, 32'h500);
        tick();
        clear_req();
        icache_miss = 1'b1;
        check("t6_valid", redirect_valid, 1);
        check("t6_cause", redirect_cause, 3);
        check("t6_pc", redirect_pc, 32'h600);
        check("t6_drop", dropped_cnt, 3);

        // Flush plus refetch over a pending return: two drops; bit0 forced low.
        must_flush          = 1'b1;
        correct_address     = 32'h1235;
        invalid_instruction = 1'b1;
        tick();
        clear_req();
        check("t7_pc", redirect_pc, 32'h1234);
        check("t7_cause", redirect_cause, 0);
        check("t7_drop", dropped_cnt, 5);

        // Flush over flush: latest wins, no drop.
        must_flush      = 1'b1;
        correct_address = 32'h2000;
        tick();
        clear_req();
        check("t8_pc", redirect_pc, 32'h2000);
        check("t8_drop", dropped_cnt, 5);

        // Drive the counter into saturation.
        for (int i = 0; i < 3; i++) begin
            invalid_instruction = 1'b1;
            tick();
        end
        clear_req();
        check("t9_sat", dropped_cnt, 7);
        invalid_instruction = 1'b1;
        tick();
        clear_req();
        check("t9_sat_hold", dropped_cnt, 7);
        check("t9_pc", redirect_pc, 32'h2000);

        // Asynchronous reset in the middle of HOLD.
        #2;
        rst_n = 1'b0;
        #1;
        check("t10_valid", redirect_valid, 0);
        check("t10_pc", redirect_pc, 0);
        check("t10_drop", dropped_cnt, 0);
        icache_miss    = 1'b0;
        redirect_ready = 1'b1;
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("t10_no_stale", redirect_valid, 0);
        check("t10_fq", fq_flush, 0);
        check("t10_drop_after", dropped_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
